sdram_rw_seq: RTL and testbench
===============================

Name: sdram_rw_seq

Overview:
Closed-page SDRAM command sequencer. It takes one read or write request at a time from the host interface and issues ACTIVE, then READ/WRITE, then the data burst and a precharge on the SDRAM command bus. It also arbitrates the periodic refresh request against host requests. It sits between the host bus interface and the SDRAM pad/data-path logic, and contains its own burst down-counter and timing counter.

Parameters:
TRCD, 2, ACTIVE-to-READ/WRITE delay in clocks (1..15)
TRP, 2, PRECHARGE-to-next-command delay in clocks (1..15)
TRFC, 7, REFRESH-to-next-command delay in clocks (1..15)
CAS_LAT, 2, READ command to first read-data clock (2 or 3)

Ports:
Clk  in  1  system clock, all logic on rising edge
Reset  in  1  synchronous, active-low reset
req  in  1  host access request; held until ack
req_wr  in  1  1 = write, 0 = read; sampled with req
req_addr  in  22  {bank[21:20], row[19:8], col[7:0]}
brst_len  in  3  burst beats minus 1 (0..7)
ack  out  1  one-clock pulse: request accepted, ACTIVE issued this clock
ref_req  in  1  refresh request level; held until ref_ack
ref_ack  out  1  one-clock pulse coincident with REFRESH command
sd_cmd  out  3  {RAS_n,CAS_n,WE_n}: NOP 111, ACT 011, RD 101, WR 100, PRE 010, REF 001
sd_ba  out  2  bank address
sd_a  out  12  row/column address; bit 10 = precharge-all / auto-precharge
dq_oe  out  1  write data drive enable
wr_next  out  1  host must present the next write beat this clock
rd_valid  out  1  read data on DQ valid this clock
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (Reset=0 at rising edge): state IDLE; sd_cmd=111, sd_ba=0, sd_a=0; ack, ref_ack, dq_oe, wr_next, rd_valid, busy all 0; counters cleared; rd_valid pipe cleared. Reset asserted mid-burst aborts at the next edge. No PRE is issued.
- States: IDLE, ACT, RCD, XFER, DRAIN, PRE, RP, REF, RFC.
- IDLE:
  - ref_req=1 -> REF. Refresh wins if req and ref_req rise in the same clock; req stays pending.
  - else req=1 -> ACT.
- ACT (1 clk): sd_cmd=ACT, sd_ba=bank, sd_a=row, ack=1. Latches addr, req_wr and brst_len. Goes to RCD if TRCD>1, else XFER.
- RCD: NOP for TRCD-1 clocks, then XFER.
- XFER:
  - First clock: sd_cmd=RD/WR, sd_a={4'b0000,col}, sd_a[10]=0. Burst counter loads brst_len.
  - Following clocks: NOP while the counter decrements to 0.
  - Beats = brst_len+1.
  - Write: dq_oe=wr_next=1 on every XFER clock.
  - Read: each XFER clock pushes a 1 into a CAS_LAT-deep pipe. rd_valid = pipe output, so it is high for brst_len+1 clocks starting CAS_LAT clocks after RD.
  - Leaves XFER in the clock after the counter reaches 0 -> DRAIN.
- DRAIN: NOP for 1 clock (write recovery) or CAS_LAT clocks (read), then PRE.
- PRE (1 clk): sd_cmd=PRE, sd_a[10]=1. Goes to RP if TRP>1, else IDLE.
- RP: NOP for TRP-1 clocks, then IDLE.
- REF (1 clk): sd_cmd=REF, ref_ack=1. Goes to RFC if TRFC>1, else IDLE.
- RFC: NOP for TRFC-1 clocks, then IDLE.
- Timer: 4 bits, loaded on state entry, decrements to 0.
- Banks are always closed in IDLE (closed-page policy).
- req deasserted before ack: no command issued.
- brst_len=0: single beat.
- req held across completion is taken as a new request in the IDLE clock.

Optional Feature:
SDRAM_AUTO_PRECHARGE_EN
- Defined:
  - RD/WR are issued with sd_a[10]=1.
  - The PRE state is skipped.
  - DRAIN goes to RP, and RP lasts TRP clocks (not TRP-1), so total access length is unchanged.
  - sd_cmd never shows PRE after an access.
- Undefined: explicit PRE as described in Behaviour.

Test Plan:
- Write, brst_len=3, defaults; req at clk N -> ACT+ack at N, NOP N+1, WR N+2, wr_next/dq_oe N+2..N+5, NOP N+6, PRE(a10=1) N+7, NOP N+8, busy low N+9.
- Read, brst_len=3, CAS_LAT=2 -> RD at N+2, rd_valid N+4..N+7, PRE N+8, IDLE N+10. Repeat with CAS_LAT=3 -> rd_valid N+5..N+8, PRE N+9.
- req and ref_req rise in the same clock M -> REF+ref_ack at M, NOP M+1..M+6, ACT+ack at M+7 for the pending req.
- Read, brst_len=0 -> exactly one RD and one rd_valid clock (N+4), PRE at N+5.
- Reset low during XFER of a brst_len=7 write -> next edge: sd_cmd=111, all outputs 0, IDLE. After release, a new read completes normally.
- SDRAM_AUTO_PRECHARGE_EN defined, write brst_len=3 -> WR with a10=1 at N+2, no PRE command, busy low at N+9.

Source files
------------

// File: rtl/sdram_rw_seq_if.sv
// Host request / SDRAM command bundle shared by the sequencer and its neighbours.
// No storage here; purely a connection bundle.
// Flow control is req-held-until-ack on the host side and level ref_req held until ref_ack.
interface sdram_rw_seq_if;
    logic        req;
    logic        req_wr;
    logic [21:0] req_addr;
    logic [2:0]  brst_len;
    logic        ack;
    logic        ref_req;
    logic        ref_ack;
    logic [2:0]  sd_cmd;
    logic [1:0]  sd_ba;
    logic [11:0] sd_a;
    logic        dq_oe;
    logic        wr_next;
    logic        rd_valid;
    logic        busy;

    // Host / refresh timer side
    modport master (
        output req, req_wr, req_addr, brst_len, ref_req,
        input  ack, ref_ack, sd_cmd, sd_ba, sd_a, dq_oe, wr_next, rd_valid, busy
    );

    // Sequencer side
    modport slave (
        input  req, req_wr, req_addr, brst_len, ref_req,
        output ack, ref_ack, sd_cmd, sd_ba, sd_a, dq_oe, wr_next, rd_valid, busy
    );
endinterface

// File: rtl/sdram_rw_seq.sv
// Closed-page SDRAM command sequencer: ACT, RD/WR burst, PRE, plus refresh arbitration.
// Latency: ACT one clock after req is seen in IDLE; RD/WR TRCD clocks after ACT.
// Backpressure: host holds req until the ack pulse; refresh beats a same-clock host request.
// Optional macro SDRAM_AUTO_PRECHARGE_EN: RD/WR carry A10=1 and the explicit PRE is dropped.
module sdram_rw_seq #(
    parameter int unsigned TRCD    = 2,
    parameter int unsigned TRP     = 2,
    parameter int unsigned TRFC    = 7,
    parameter int unsigned CAS_LAT = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    sdram_rw_seq_if.slave     bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACT,
        S_RCD,
        S_XFER,
        S_DRAIN,
        S_PRE,
        S_RP,
        S_REF,
        S_RFC
    } state_t;

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;

    // Timer holds "remaining clocks minus one" for the current wait state.
    localparam logic [3:0] RCD_LD    = (TRCD > 1) ? 4'(TRCD - 2) : 4'd0;
    localparam logic [3:0] RFC_LD    = (TRFC > 1) ? 4'(TRFC - 2) : 4'd0;
    localparam logic [3:0] DRN_RD_LD = 4'(CAS_LAT - 1);
`ifdef SDRAM_AUTO_PRECHARGE_EN
    // The RP wait absorbs the clock the PRE command would have used.
    localparam logic [3:0] RP_LD   = 4'(TRP - 1);
    localparam logic       AP_BIT  = 1'b1;
`else
    localparam logic [3:0] RP_LD   = (TRP > 1) ? 4'(TRP - 2) : 4'd0;
    localparam logic       AP_BIT  = 1'b0;
`endif

    state_t               state;
    state_t               nxt;
    logic [3:0]           timer;
    logic [3:0]           tmr_ld;
    logic [2:0]           bcnt;
    logic                 first;
    logic                 wr_q;
    logic [21:0]          addr_q;
    logic [2:0]           blen_q;
    logic [CAS_LAT-1:0]   rd_pipe;
    logic                 rd_push;

    // Refresh has priority; a host request stays pending behind it.
    function automatic state_t arb(input logic host_req, input logic refr_req);
        if (refr_req) begin
            return S_REF;
        end else if (host_req) begin
            return S_ACT;
        end
        return S_IDLE;
    endfunction

    // Next-state and timer reload value for the state being entered.
    always_comb begin
        nxt    = state;
        tmr_ld = 4'd0;
        unique case (state)
            S_IDLE:  nxt = arb(bus.req, bus.ref_req);
            S_ACT:   nxt = (TRCD > 1) ? S_RCD : S_XFER;
            S_RCD:   if (timer == 4'd0) nxt = S_XFER;
            S_XFER:  if (bcnt == 3'd0) nxt = S_DRAIN;
            S_DRAIN: begin
                if (timer == 4'd0) begin
`ifdef SDRAM_AUTO_PRECHARGE_EN
                    nxt = S_RP;
`else
                    nxt = S_PRE;
`endif
                end
            end
            S_PRE:   nxt = (TRP > 1) ? S_RP : arb(bus.req, bus.ref_req);
            // Wait states end straight into arbitration so a queued request loses no clock.
            S_RP:    if (timer == 4'd0) nxt = arb(bus.req, bus.ref_req);
            S_REF:   nxt = (TRFC > 1) ? S_RFC : arb(bus.req, bus.ref_req);
            S_RFC:   if (timer == 4'd0) nxt = arb(bus.req, bus.ref_req);
            default: nxt = S_IDLE;
        endcase

        unique case (nxt)
            S_RCD:   tmr_ld = RCD_LD;
            S_DRAIN: tmr_ld = wr_q ? 4'd0 : DRN_RD_LD;
            S_RP:    tmr_ld = RP_LD;
            S_RFC:   tmr_ld = RFC_LD;
            default: tmr_ld = 4'd0;
        endcase
    end

    assign rd_push = (state == S_XFER) && !wr_q;

    // State register, wait timer, burst counter, request latch and read-valid pipe.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state   <= S_IDLE;
            timer   <= 4'd0;
            bcnt    <= 3'd0;
            first   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 22'd0;
            blen_q  <= 3'd0;
            rd_pipe <= '0;
        end else begin
            state <= nxt;

            if (nxt != state) begin
                timer <= tmr_ld;
            end else if (timer != 4'd0) begin
                timer <= timer - 4'd1;
            end

            if (nxt == S_ACT) begin
                addr_q <= bus.req_addr;
                wr_q   <= bus.req_wr;
                blen_q <= bus.brst_len;
            end

            first <= (nxt == S_XFER) && (state != S_XFER);
            if ((nxt == S_XFER) && (state != S_XFER)) begin
                bcnt <= blen_q;
            end else if ((state == S_XFER) && (bcnt != 3'd0)) begin
                bcnt <= bcnt - 3'd1;
            end

            if (CAS_LAT > 1) begin
                rd_pipe <= {rd_pipe[CAS_LAT-2:0], rd_push};
            end else begin
                rd_pipe <= rd_push;
            end
        end
    end

    // Command bus and handshake decode from the current state.
    always_comb begin
        bus.sd_cmd  = CMD_NOP;
        bus.sd_ba   = 2'd0;
        bus.sd_a    = 12'd0;
        bus.ack     = 1'b0;
        bus.ref_ack = 1'b0;
        bus.dq_oe   = 1'b0;
        bus.wr_next = 1'b0;
        unique case (state)
            S_ACT: begin
                bus.sd_cmd = CMD_ACT;
                bus.sd_ba  = addr_q[21:20];
                bus.sd_a   = addr_q[19:8];
                bus.ack    = 1'b1;
            end
            S_XFER: begin
                if (first) begin
                    bus.sd_cmd    = wr_q ? CMD_WR : CMD_RD;
                    bus.sd_ba     = addr_q[21:20];
                    bus.sd_a      = {4'b0000, addr_q[7:0]};
                    bus.sd_a[10]  = AP_BIT;
                end
                bus.dq_oe   = wr_q;
                bus.wr_next = wr_q;
            end
            S_PRE: begin
                bus.sd_cmd   = CMD_PRE;
                bus.sd_ba    = addr_q[21:20];
                bus.sd_a[10] = 1'b1;
            end
            S_REF: begin
                bus.sd_cmd  = CMD_REF;
                bus.ref_ack = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.rd_valid = rd_pipe[CAS_LAT-1];
    assign bus.busy     = (state != S_IDLE);

endmodule

// File: tb/tb_sdram_rw_seq.sv
// Directed bench: two sequencers (CAS latency 2 and 3) share one stimulus stream.
module tb_sdram_rw_seq;

    localparam logic [2:0] NOP  = 3'b111;
    localparam logic [2:0] ACT  = 3'b011;
    localparam logic [2:0] RD   = 3'b101;
    localparam logic [2:0] WR   = 3'b100;
    localparam logic [2:0] PRE  = 3'b010;
    localparam logic [2:0] REFC = 3'b001;
`ifdef SDRAM_AUTO_PRECHARGE_EN
    localparam logic [2:0] PRE_E = NOP;
    localparam logic       AP    = 1'b1;
`else
    localparam logic [2:0] PRE_E = PRE;
    localparam logic       AP    = 1'b0;
`endif

    logic        Clk;
    logic        Reset;
    logic        req, req_wr, ref_req;
    logic [21:0] req_addr;
    logic [2:0]  brst_len;

    int vec  = 0;
    int errs = 0;

    sdram_rw_seq_if b2 ();
    sdram_rw_seq_if b3 ();

    assign b2.req = req;      assign b3.req = req;
    assign b2.req_wr = req_wr;   assign b3.req_wr = req_wr;
    assign b2.req_addr = req_addr; assign b3.req_addr = req_addr;
    assign b2.brst_len = brst_len; assign b3.brst_len = brst_len;
    assign b2.ref_req = ref_req;  assign b3.ref_req = ref_req;

    sdram_rw_seq #(.TRCD(2), .TRP(2), .TRFC(7), .CAS_LAT(2)) dut2 (.Clk(Clk), .Reset(Reset), .bus(b2));
    sdram_rw_seq #(.TRCD(2), .TRP(2), .TRFC(7), .CAS_LAT(3)) dut3 (.Clk(Clk), .Reset(Reset), .bus(b3));

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // 20-clock trace captured after a request is raised
    logic [2:0]  c2 [20];
    logic [2:0]  c3 [20];
    logic [11:0] a2 [20];
    logic [1:0]  ba2 [20];
    logic        ak2 [20];
    logic        rk2 [20];
    logic        rv2 [20];
    logic        rv3 [20];
    logic        wn2 [20];
    logic        oe2 [20];
    logic        bz2 [20];
    logic        bz3 [20];

    task automatic capture(input logic wr, input logic [2:0] bl, input logic [21:0] ad, input logic with_ref);
        @(negedge Clk);
        req = 1'b1; req_wr = wr; brst_len = bl; req_addr = ad; ref_req = with_ref;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clk);
            c2[k] = b2.sd_cmd;  c3[k] = b3.sd_cmd;
            a2[k] = b2.sd_a;    ba2[k] = b2.sd_ba;
            ak2[k] = b2.ack;    rk2[k] = b2.ref_ack;
            rv2[k] = b2.rd_valid; rv3[k] = b3.rd_valid;
            wn2[k] = b2.wr_next;  oe2[k] = b2.dq_oe;
            bz2[k] = b2.busy;     bz3[k] = b3.busy;
            if (b2.ack) req = 1'b0;
            if (b2.ref_ack) ref_req = 1'b0;
        end
        req = 1'b0; ref_req = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while ((b2.busy || b3.busy) && cnt < 40) begin
            @(negedge Clk);
            cnt++;
        end
        vec++;
        if (b2.busy || b3.busy) begin
            errs++;
            $display("FAIL wait_idle: busy2=%b busy3=%b after 40 clocks, required 0", b2.busy, b3.busy);
        end
    endtask

    function automatic int first_hit(input logic sel_ref);
        for (int k = 0; k < 20; k++) begin
            if (sel_ref ? rk2[k] : ak2[k]) return k;
        end
        return -1;
    endfunction

    task automatic check_start(input string nm, input int got, output int n);
        vec++;
        if (got !== 0) begin
            errs++;
            $display("FAIL %s start index: got %0d required 0", nm, got);
        end
        n = (got < 0 || got > 6) ? 0 : got;
    endtask

    task automatic test_reset();
        Reset = 1'b0; req = 1'b0; req_wr = 1'b0; ref_req = 1'b0; req_addr = 22'd0; brst_len = 3'd0;
        repeat (3) @(negedge Clk);
        vec++; if (b2.sd_cmd !== NOP) begin errs++; $display("FAIL rst_cmd: got %b required %b", b2.sd_cmd, NOP); end
        vec++; if (b2.sd_ba !== 2'd0) begin errs++; $display("FAIL rst_ba: got %0d required 0", b2.sd_ba); end
        vec++; if (b2.sd_a !== 12'd0) begin errs++; $display("FAIL rst_a: got %h required 000", b2.sd_a); end
        vec++;
        if ({b2.ack, b2.ref_ack, b2.dq_oe, b2.wr_next, b2.rd_valid, b2.busy} !== 6'd0) begin
            errs++; $display("FAIL rst_flags: got %b required 000000",
                             {b2.ack, b2.ref_ack, b2.dq_oe, b2.wr_next, b2.rd_valid, b2.busy});
        end
        vec++; if ({b3.sd_cmd, b3.busy, b3.rd_valid} !== {NOP, 2'b00}) begin
            errs++; $display("FAIL rst_dut3: got %b required 11100", {b3.sd_cmd, b3.busy, b3.rd_valid});
        end
        Reset = 1'b1;
        @(negedge Clk);
        vec++; if (b2.busy !== 1'b0) begin errs++; $display("FAIL idle_no_req: busy got %b required 0", b2.busy); end
    endtask

    task automatic test_write();
        logic [2:0] e_cmd [14];
        logic [13:0] e_wn, e_bz;
        int n;
        e_cmd = '{ACT, NOP, WR, NOP, NOP, NOP, NOP, PRE_E, NOP, NOP, NOP, NOP, NOP, NOP};
        e_wn  = 14'b00000000111100;
        e_bz  = 14'b00000111111111;
        capture(1'b1, 3'd3, {2'b10, 12'hABC, 8'h5A}, 1'b0);
        check_start("wr", first_hit(1'b0), n);
        for (int k = 0; k < 14; k++) begin
            vec++; if (c2[n+k] !== e_cmd[k]) begin errs++; $display("FAIL wr_cmd[N+%0d]: got %b required %b", k, c2[n+k], e_cmd[k]); end
            vec++; if (wn2[n+k] !== e_wn[k] || oe2[n+k] !== e_wn[k]) begin
                errs++; $display("FAIL wr_next/oe[N+%0d]: got %b/%b required %b", k, wn2[n+k], oe2[n+k], e_wn[k]);
            end
            vec++; if (bz2[n+k] !== e_bz[k]) begin errs++; $display("FAIL wr_busy[N+%0d]: got %b required %b", k, bz2[n+k], e_bz[k]); end
        end
        vec++; if ({ba2[n], a2[n]} !== {2'b10, 12'hABC}) begin errs++; $display("FAIL wr_act_addr: got %h/%h required 2/abc", ba2[n], a2[n]); end
        vec++; if (a2[n+2] !== {1'b0, AP, 10'h05A}) begin errs++; $display("FAIL wr_col_addr: got %h required %h", a2[n+2], {1'b0, AP, 10'h05A}); end
`ifndef SDRAM_AUTO_PRECHARGE_EN
        vec++; if (a2[n+7][10] !== 1'b1) begin errs++; $display("FAIL wr_pre_a10: got %b required 1", a2[n+7][10]); end
`endif
        wait_idle();
    endtask

    task automatic test_read_burst();
        logic [2:0] e_c2 [14];
        logic [2:0] e_c3 [14];
        logic [13:0] e_rv2, e_rv3, e_bz2, e_bz3;
        int n;
        e_c2  = '{ACT, NOP, RD, NOP, NOP, NOP, NOP, NOP, PRE_E, NOP, NOP, NOP, NOP, NOP};
        e_c3  = '{ACT, NOP, RD, NOP, NOP, NOP, NOP, NOP, NOP, PRE_E, NOP, NOP, NOP, NOP};
        e_rv2 = 14'b00000011110000;
        e_rv3 = 14'b00000111100000;
        e_bz2 = 14'b00001111111111;
        e_bz3 = 14'b00011111111111;
        capture(1'b0, 3'd3, {2'b01, 12'h123, 8'hC3}, 1'b0);
        check_start("rd", first_hit(1'b0), n);
        for (int k = 0; k < 14; k++) begin
            vec++; if (c2[n+k] !== e_c2[k]) begin errs++; $display("FAIL rd_cmd_cl2[N+%0d]: got %b required %b", k, c2[n+k], e_c2[k]); end
            vec++; if (c3[n+k] !== e_c3[k]) begin errs++; $display("FAIL rd_cmd_cl3[N+%0d]: got %b required %b", k, c3[n+k], e_c3[k]); end
            vec++; if (rv2[n+k] !== e_rv2[k]) begin errs++; $display("FAIL rd_valid_cl2[N+%0d]: got %b required %b", k, rv2[n+k], e_rv2[k]); end
            vec++; if (rv3[n+k] !== e_rv3[k]) begin errs++; $display("FAIL rd_valid_cl3[N+%0d]: got %b required %b", k, rv3[n+k], e_rv3[k]); end
            vec++; if (bz2[n+k] !== e_bz2[k] || bz3[n+k] !== e_bz3[k]) begin
                errs++; $display("FAIL rd_busy[N+%0d]: got %b/%b required %b/%b", k, bz2[n+k], bz3[n+k], e_bz2[k], e_bz3[k]);
            end
            vec++; if (wn2[n+k] !== 1'b0) begin errs++; $display("FAIL rd_wr_next[N+%0d]: got %b required 0", k, wn2[n+k]); end
        end
        vec++; if ({ba2[n], a2[n]} !== {2'b01, 12'h123}) begin errs++; $display("FAIL rd_act_addr: got %h/%h required 1/123", ba2[n], a2[n]); end
        vec++; if ({ba2[n+2], a2[n+2]} !== {2'b01, 1'b0, AP, 10'h0C3}) begin
            errs++; $display("FAIL rd_col_addr: got %h/%h required 1/%h", ba2[n+2], a2[n+2], {1'b0, AP, 10'h0C3});
        end
        wait_idle();
    endtask

    task automatic test_single_beat();
        logic [2:0] e_cmd [14];
        logic [13:0] e_rv, e_bz;
        int n, nrd, nrv;
        e_cmd = '{ACT, NOP, RD, NOP, NOP, PRE_E, NOP, NOP, NOP, NOP, NOP, NOP, NOP, NOP};
        e_rv  = 14'b00000000010000;
        e_bz  = 14'b00000001111111;
        capture(1'b0, 3'd0, {2'b11, 12'hFFF, 8'h01}, 1'b0);
        check_start("rd1", first_hit(1'b0), n);
        for (int k = 0; k < 14; k++) begin
            vec++; if (c2[n+k] !== e_cmd[k]) begin errs++; $display("FAIL rd1_cmd[N+%0d]: got %b required %b", k, c2[n+k], e_cmd[k]); end
            vec++; if (rv2[n+k] !== e_rv[k]) begin errs++; $display("FAIL rd1_valid[N+%0d]: got %b required %b", k, rv2[n+k], e_rv[k]); end
            vec++; if (bz2[n+k] !== e_bz[k]) begin errs++; $display("FAIL rd1_busy[N+%0d]: got %b required %b", k, bz2[n+k], e_bz[k]); end
        end
        nrd = 0; nrv = 0;
        for (int k = 0; k < 20; k++) begin
            if (c2[k] === RD) nrd++;
            if (rv2[k] === 1'b1) nrv++;
        end
        vec++; if (nrd != 1 || nrv != 1) begin errs++; $display("FAIL rd1_counts: RD=%0d valid=%0d required 1/1", nrd, nrv); end
        wait_idle();
    endtask

    task automatic test_refresh_priority();
        logic [2:0] e_cmd [10];
        logic [9:0] e_rk, e_ak;
        int m;
        e_cmd = '{REFC, NOP, NOP, NOP, NOP, NOP, NOP, ACT, NOP, WR};
        e_rk  = 10'b0000000001;
        e_ak  = 10'b0010000000;
        capture(1'b1, 3'd0, {2'b00, 12'h456, 8'h10}, 1'b1);
        check_start("ref", first_hit(1'b1), m);
        for (int k = 0; k < 10; k++) begin
            vec++; if (c2[m+k] !== e_cmd[k]) begin errs++; $display("FAIL ref_cmd[M+%0d]: got %b required %b", k, c2[m+k], e_cmd[k]); end
            vec++; if (rk2[m+k] !== e_rk[k] || ak2[m+k] !== e_ak[k]) begin
                errs++; $display("FAIL ref_ack/ack[M+%0d]: got %b/%b required %b/%b", k, rk2[m+k], ak2[m+k], e_rk[k], e_ak[k]);
            end
        end
        vec++; if (a2[m+7] !== 12'h456) begin errs++; $display("FAIL ref_pending_row: got %h required 456", a2[m+7]); end
        wait_idle();
    endtask

    task automatic test_reset_mid_burst();
        int cnt;
        @(negedge Clk);
        req = 1'b1; req_wr = 1'b1; brst_len = 3'd7; req_addr = {2'b10, 12'h0F0, 8'h33}; ref_req = 1'b0;
        cnt = 0;
        while (b2.sd_cmd !== WR && cnt < 20) begin
            @(negedge Clk);
            if (b2.ack) req = 1'b0;
            cnt++;
        end
        req = 1'b0;
        vec++; if (b2.sd_cmd !== WR) begin errs++; $display("FAIL mid_wr_seen: got %b required %b within 20 clocks", b2.sd_cmd, WR); end
        repeat (2) @(negedge Clk);
        vec++; if (b2.dq_oe !== 1'b1) begin errs++; $display("FAIL mid_oe_before: got %b required 1", b2.dq_oe); end
        Reset = 1'b0;
        @(negedge Clk);
        vec++; if (b2.sd_cmd !== NOP || b3.sd_cmd !== NOP) begin errs++; $display("FAIL mid_rst_cmd: got %b/%b required 111", b2.sd_cmd, b3.sd_cmd); end
        vec++;
        if ({b2.sd_ba, b2.sd_a, b2.ack, b2.ref_ack, b2.dq_oe, b2.wr_next, b2.rd_valid, b2.busy, b3.busy} !== 21'd0) begin
            errs++; $display("FAIL mid_rst_outs: ba=%h a=%h ack=%b rack=%b oe=%b wn=%b rv=%b busy=%b/%b required all 0",
                             b2.sd_ba, b2.sd_a, b2.ack, b2.ref_ack, b2.dq_oe, b2.wr_next, b2.rd_valid, b2.busy, b3.busy);
        end
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        vec++; if (b2.sd_cmd !== NOP || b2.busy !== 1'b0) begin errs++; $display("FAIL mid_after_release: cmd=%b busy=%b required 111/0", b2.sd_cmd, b2.busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_burst();
        test_single_beat();
        test_refresh_priority();
        test_reset_mid_burst();
        test_read_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
